// File: rtl/frame_readout.sv
// Raster timing generator that streams a frame buffer out as RGB video.
// Read strobes lead the registered video outputs by one clock to cover RAM latency.
module frame_readout #(
   parameter int H_ACTIVE = 4,
   parameter int H_FP     = 1,
   parameter int H_SYNC   = 1,
   parameter int H_BP     = 1,
   parameter int V_ACTIVE = 3,
   parameter int V_FP     = 1,
   parameter int V_SYNC   = 1,
   parameter int V_BP     = 1,
   parameter bit SYNC_POL = 1'b1,
   parameter int ADDR_W   = 12
) (
   input  logic              PixelClk,
   input  logic              aRst,
   input  logic              pEnable,
   output logic              pRdEn,
   output logic [ADDR_W-1:0] pRdAddr,
   input  logic [23:0]       pRdData,
   output logic              pVDE,
   output logic              pHSync,
   output logic              pVSync,
   output logic [23:0]       pData,
   output logic              pFrameStart
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW = $clog2(H_TOTAL + 1);
   localparam int VW = $clog2(V_TOTAL + 1);

   localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state;
   logic [HW-1:0] hcnt;
   logic [VW-1:0] vcnt;
   logic          run;
   logic          h_act;
   logic          v_act;
   logic          h_sync;
   logic          v_sync;
   logic          h_end;
   logic          v_end;

   assign run    = (state == RUN);
   assign h_act  = (hcnt < H_ACT);
   assign v_act  = (vcnt < V_ACT);
   assign h_sync = (hcnt >= H_SS) && (hcnt < H_SE);
   assign v_sync = (vcnt >= V_SS) && (vcnt < V_SE);
   assign h_end  = (hcnt == H_LAST);
   assign v_end  = (vcnt == V_LAST);

   assign pRdEn = run && h_act && v_act;

   // Registered pVDE marks the cycle in which the buffer returns read data.
   assign pData = pVDE ? pRdData : 24'h000000;

   always_ff @(posedge PixelClk or posedge aRst) begin
      if (aRst) begin
         state       <= IDLE;
         hcnt        <= '0;
         vcnt        <= '0;
         pRdAddr     <= '0;
         pVDE        <= 1'b0;
         pHSync      <= ~SYNC_POL;
         pVSync      <= ~SYNC_POL;
         pFrameStart <= 1'b0;
      end else begin
         pVDE        <= pRdEn;
         pHSync      <= (run && h_sync) ? SYNC_POL : ~SYNC_POL;
         pVSync      <= (run && v_sync) ? SYNC_POL : ~SYNC_POL;
         pFrameStart <= run && (hcnt == '0) && (vcnt == '0);
         unique case (state)
            IDLE: begin
               if (pEnable) begin
                  state   <= RUN;
                  hcnt    <= '0;
                  vcnt    <= '0;
                  pRdAddr <= '0;
               end
            end
            RUN: begin
               if (pRdEn)
                  pRdAddr <= pRdAddr + ADDR_W'(1);
               if (h_end) begin
                  hcnt <= '0;
                  if (v_end) begin
                     // Enable is only honoured here so frames are never cut short.
                     vcnt    <= '0;
                     pRdAddr <= '0;
                     if (!pEnable)
                        state <= IDLE;
                  end else begin
                     vcnt <= vcnt + VW'(1);
                  end
               end else begin
                  hcnt <= hcnt + HW'(1);
               end
            end
         endcase
      end
   end

endmodule
